// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs a single-outstanding imem handshake
// and holds the IF/ID instruction. Define FETCH_PERF_CNT_EN to add performance counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] redirect_pc,
  input  logic        load_use,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        stop,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        imem_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [3:0]  TMO_LIMIT = 4'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic [3:0]  tmo_cnt;
  logic        consume;
  logic        fetch_go;
  logic        accept;
  logic        timeout_hit;

  assign consume     = if_valid & id_ready & ~load_use & ~branch;
  assign fetch_go    = (state == S_IDLE) & ~branch & ~load_use & (~if_valid | consume);
  assign accept      = (state == S_WAIT) & imem_ack & ~branch;
  assign timeout_hit = (state != S_IDLE) && (tmo_cnt == TMO_LIMIT);

  assign imem_addr = fetch_pc;
  assign stop      = load_use & ~branch;
  assign flush_id  = branch;
  assign flush_ex  = branch | load_use;

  // The timeout counter restarts whenever the state changes, so a drop
  // following a redirect gets its own full window for the stale ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tmo_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (state == S_IDLE || state_next != state)
        tmo_cnt <= 4'd0;
      else
        tmo_cnt <= tmo_cnt + 4'd1;
    end
  end

  // Branch beats ack beats timeout; a redirect with no ack leaves one stale ack to swallow.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (fetch_go) state_next = S_WAIT;
      S_WAIT: begin
        if (branch)
          state_next = imem_ack ? S_IDLE : S_DROP;
        else if (imem_ack || timeout_hit)
          state_next = S_IDLE;
      end
      S_DROP: if (imem_ack || timeout_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    imem_err = 1'b0;
    if (!reset) begin
      imem_req = fetch_go;
      case (state)
        S_WAIT:  imem_err = timeout_hit & ~imem_ack & ~branch;
        S_DROP:  imem_err = timeout_hit & ~imem_ack;
        default: imem_err = 1'b0;
      endcase
    end
  end

  // Fetch PC and IF/ID register; fetch_pc only advances on an accepted response,
  // so a timeout in S_WAIT naturally re-issues the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
      if_pc    <= 32'h0000_0000;
    end else begin
      if (branch)
        fetch_pc <= redirect_pc;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;

      if (branch)
        if_valid <= 1'b0;
      else if (accept)
        if_valid <= 1'b1;
      else if (consume)
        if_valid <= 1'b0;

      if (accept) begin
        if_inst <= imem_rdata;
        if_pc   <= fetch_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= 32'd0;
      perf_stall <= 32'd0;
      perf_flush <= 32'd0;
    end else begin
      if (accept) perf_fetch <= perf_fetch + 32'd1;
      if (stop)   perf_stall <= perf_stall + 32'd1;
      if (branch) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table for sequential fetch, stalls and
// redirects, plus hand sequences for the ack timeout and reset in the middle of a handshake.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        branch;
  logic [31:0] redirect_pc;
  logic        load_use;
  logic        id_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        stop;
  logic        flush_id;
  logic        flush_ex;
  logic        imem_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
  localparam logic [31:0] I3 = 32'h0040_0213, I4 = 32'h0050_0293, I5 = 32'h0060_0313;
  localparam logic [31:0] I6 = 32'h0070_0393, I7 = 32'h0080_0413;

  typedef struct {
    logic        br;
    logic [31:0] rpc;
    logic        lu;
    logic        rdy;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stp;
    logic        fid;
    logic        fex;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .branch(branch), .redirect_pc(redirect_pc),
    .load_use(load_use), .id_ready(id_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .stop(stop), .flush_id(flush_id), .flush_ex(flush_ex), .imem_err(imem_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic [31:0] rpc, input logic lu,
                               input logic rdy, input logic ack, input logic [31:0] rdata);
    branch      = br;
    redirect_pc = rpc;
    load_use    = lu;
    id_ready    = rdy;
    imem_ack    = ack;
    imem_rdata  = rdata;
  endtask

  function automatic vec_t mk(input logic br, input logic [31:0] rpc, input logic lu,
                              input logic rdy, input logic ack, input logic [31:0] rdata,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic stp, input logic fid, input logic fex);
    vec_t v;
    v.br = br; v.rpc = rpc; v.lu = lu; v.rdy = rdy; v.ack = ack; v.rdata = rdata;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.inst = inst;
    v.stp = stp; v.fid = fid; v.fex = fex; v.err = 1'b0;
    return v;
  endfunction

  // Inputs applied at the falling edge, outputs sampled 1ns later, then advance a cycle.
  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v.br, v.rpc, v.lu, v.rdy, v.ack, v.rdata);
    #1;
    checkOutput($sformatf("v%0d.req", idx), 32'(imem_req), 32'(v.req));
    checkOutput($sformatf("v%0d.addr", idx), imem_addr, v.addr);
    checkOutput($sformatf("v%0d.valid", idx), 32'(if_valid), 32'(v.valid));
    checkOutput($sformatf("v%0d.if_pc", idx), if_pc, v.pc);
    if (v.valid) checkOutput($sformatf("v%0d.if_inst", idx), if_inst, v.inst);
    checkOutput($sformatf("v%0d.stop", idx), 32'(stop), 32'(v.stp));
    checkOutput($sformatf("v%0d.flush_id", idx), 32'(flush_id), 32'(v.fid));
    checkOutput($sformatf("v%0d.flush_ex", idx), 32'(flush_ex), 32'(v.fex));
    checkOutput($sformatf("v%0d.err", idx), 32'(imem_err), 32'(v.err));
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".req"}, 32'(imem_req), 32'd0);
    checkOutput({tag, ".valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, ".if_inst"}, if_inst, 32'h0000_0013);
    checkOutput({tag, ".if_pc"}, if_pc, 32'd0);
    checkOutput({tag, ".addr"}, imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, ".perf_fetch"}, perf_fetch, 32'd0);
    checkOutput({tag, ".perf_stall"}, perf_stall, 32'd0);
    checkOutput({tag, ".perf_flush"}, perf_flush, 32'd0);
`endif
  endtask

  initial begin
    int err_pulses;
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;

    //            br  rpc           lu  rdy ack rdata        req addr          vld pc            inst stp fid fex
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'd0,        0, 32'd0,        0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I0,           0, 32'd0,        0, 32'd0,        0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'd4,        1, 32'd0,        I0, 0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I1,           0, 32'd4,        0, 32'd0,        0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'd8,        1, 32'd4,        I1, 0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I2,           0, 32'd8,        0, 32'd4,        0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        1, 1, 0, 32'd0,        0, 32'd12,       1, 32'd8,        I2, 1, 0, 1));
    vecs.push_back(mk(0, 32'd0,        1, 1, 0, 32'd0,        0, 32'd12,       1, 32'd8,        I2, 1, 0, 1));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'd12,       1, 32'd8,        I2, 0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I3,           0, 32'd12,       0, 32'd8,        0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'd16,       1, 32'd12,       I3, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100,      0, 1, 0, 32'd0,        0, 32'd16,       0, 32'd12,       0,  0, 1, 1));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        0, 32'h100,      0, 32'd12,       0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, 32'hDEAD,     0, 32'h100,      0, 32'd12,       0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'h100,      0, 32'd12,       0,  0, 0, 0));
    vecs.push_back(mk(1, 32'h200,      0, 1, 1, 32'hBEEF,     0, 32'h100,      0, 32'd12,       0,  0, 1, 1));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'h200,      0, 32'd12,       0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I4,           0, 32'h200,      0, 32'd12,       0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 0, 0, 32'd0,        0, 32'h204,      1, 32'h200,      I4, 0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 0, 0, 32'd0,        0, 32'h204,      1, 32'h200,      I4, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 32'd0,       0, 32'h204,      1, 32'h200,      I4, 0, 1, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 0, 0, 32'd0,       0, 32'hFFFF_FFFC, 0, 32'h200,     0,  0, 1, 1));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'hFFFF_FFFC, 0, 32'h200,     0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I5,           0, 32'hFFFF_FFFC, 0, 32'h200,     0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 0, 32'd0,        1, 32'd0,        1, 32'hFFFF_FFFC, I5, 0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 1, 1, I6,           0, 32'd0,        0, 32'hFFFF_FFFC, 0,  0, 0, 0));
    vecs.push_back(mk(0, 32'd0,        0, 0, 0, 32'd0,        0, 32'd4,        1, 32'd0,        I6, 0, 0, 0));

    foreach (vecs[i]) runVector(vecs[i], i);

    // Ack timeout: redirect to 20, request it, then withhold the ack.
    applyStimulus(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("tmo.redirect_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    #1;
    checkOutput("tmo.req", 32'(imem_req), 32'd1);
    checkOutput("tmo.addr", imem_addr, 32'd20);
    @(negedge clk);
    err_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (imem_err) err_pulses++;
      if (imem_req) checkOutput($sformatf("tmo.wait%0d.req", i), 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    checkOutput("tmo.early_err", 32'(err_pulses), 32'd0);
    #1;
    checkOutput("tmo.err", 32'(imem_err), 32'd1);
    checkOutput("tmo.err_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("tmo.reissue_req", 32'(imem_req), 32'd1);
    checkOutput("tmo.reissue_addr", imem_addr, 32'd20);
    checkOutput("tmo.err_cleared", 32'(imem_err), 32'd0);
    @(negedge clk);

    // Reset while waiting on that request; stale ack lands right after release.
    reset = 1'b1;
    #1;
    checkOutput("rst_wait.req", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1;
    checkResetState("rst_wait");
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBAD0);
    #1;
    checkOutput("rst_stale.req", 32'(imem_req), 32'd1);
    checkOutput("rst_stale.addr", imem_addr, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    #1;
    checkOutput("rst_after.valid", 32'(if_valid), 32'd0);
    checkOutput("rst_after.req", 32'(imem_req), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, I7);
    #1;
    checkOutput("rst_ack.valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    #1;
    checkOutput("rst_fill.valid", 32'(if_valid), 32'd1);
    checkOutput("rst_fill.if_pc", if_pc, 32'd0);
    checkOutput("rst_fill.if_inst", if_inst, I7);
    checkOutput("rst_fill.req", 32'(imem_req), 32'd1);
    checkOutput("rst_fill.addr", imem_addr, 32'd4);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer for the 5-stage pipeline.
- Owns the fetch PC and drives a single-outstanding request/ack handshake to instruction memory.
- Holds the fetched instruction in an IF/ID output register.
- Arbitrates between sequential fetch, EX-stage branch redirect and load-use stall, and generates the pipeline flush/stop controls.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
ACK_TIMEOUT, 15, max cycles in S_WAIT/S_DROP before imem_err pulses (4-bit counter)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
branch  input  1  EX-stage taken branch/jump redirect this cycle
redirect_pc  input  32  redirect target, valid when branch=1
load_use  input  1  hazard unit: ID must stall one cycle
id_ready  input  1  ID stage can accept the held instruction
imem_req  output  1  one-cycle request strobe to instruction memory
imem_addr  output  32  request address (= fetch_pc while imem_req)
imem_ack  input  1  response valid; at least 1 cycle after imem_req
imem_rdata  input  32  instruction word, valid with imem_ack
if_valid  output  1  if_inst/if_pc hold a valid instruction
if_inst  output  32  held instruction
if_pc  output  32  PC of held instruction
stop  output  1  freeze IF/ID and earlier (load_use & ~branch)
flush_id  output  1  kill instruction in ID (= branch)
flush_ex  output  1  insert bubble into EX (= branch | load_use)
imem_err  output  1  one-cycle pulse on ack timeout

Behaviour:
- Reset, synchronous, checked every edge including mid-handshake:
  - state=S_IDLE, fetch_pc=RESET_PC, if_valid=0, if_inst=32'h0000_0013 (nop), if_pc=0, timeout counter=0.
  - imem_req=0 during reset.
  - An ack arriving in the first cycle after reset is ignored.
- Consume event: if_valid & id_ready & ~load_use & ~branch. On consume, if_valid clears next edge unless refilled on the same edge.
- S_IDLE:
  - branch=1: fetch_pc<=redirect_pc; if_valid<=0; no request.
  - Otherwise, if ~load_use and (~if_valid or consume): imem_req=1, imem_addr=fetch_pc, go to S_WAIT.
  - Otherwise stay.
- S_WAIT, priority branch > ack:
  - branch & imem_ack: discard rdata; fetch_pc<=redirect_pc; if_valid<=0; go to S_IDLE.
  - branch & ~imem_ack: fetch_pc<=redirect_pc; if_valid<=0; go to S_DROP.
  - imem_ack only: if_inst<=imem_rdata; if_pc<=fetch_pc; if_valid<=1; fetch_pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0); go to S_IDLE.
- S_DROP:
  - Waits for the stale ack, discards it, goes to S_IDLE.
  - Another branch here overwrites fetch_pc again and stays in S_DROP.
- Timeout:
  - Counter increments each cycle in S_WAIT/S_DROP and clears on leaving.
  - At ACK_TIMEOUT: imem_err pulses; go to S_IDLE (S_WAIT re-issues the same fetch_pc; S_DROP does not).
- Combinational outputs:
  - stop=load_use&~branch.
  - flush_id=branch.
  - flush_ex=branch|load_use.
- Held-data rule: if_inst/if_pc stay unchanged while if_valid=1 and not consumed.
- Throughput: one instruction per 2 cycles minimum with 1-cycle memory latency.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetch (32), perf_stall (32), perf_flush (32). All clear on reset and wrap at 2^32.
  - perf_fetch increments on each accepted (non-discarded) ack.
  - perf_stall increments each cycle stop=1.
  - perf_flush increments each cycle branch=1.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0, memory latency 1, id_ready=1 -> requests at addr 0,4,8 on cycles 1,3,5; if_pc sequence 0,4,8; if_valid rises the cycle after each ack.
2. load_use=1 for 2 cycles while if_valid=1 with if_pc=8 -> stop=1 and flush_ex=1 both cycles; no imem_req; if_pc stays 8; fetch resumes at 12 afterwards.
3. branch=1, redirect_pc=32'h100, during S_WAIT for addr 16, ack 2 cycles later with rdata 32'hDEAD -> rdata discarded; next request at 32'h100; flush_id=1 for exactly 1 cycle.
4. branch and imem_ack in the same cycle (redirect 32'h200) -> if_valid=0; next request addr 32'h200, issued the following cycle.
5. No ack for 15 cycles after request at addr 20 -> imem_err pulses once; request re-issued at addr 20.
6. Reset asserted in S_WAIT, ack arrives the cycle after reset deasserts -> ack ignored; first request at RESET_PC; if_valid=0 until that request's ack.
